// File: rtl/mult_pkg.sv
// Shared types and default widths for the sequential shift-add multiplier.
package mult_pkg;

  localparam int unsigned WIDTH_M_DEF = 16;
  localparam int unsigned WIDTH_C_DEF = 5;
  localparam int unsigned STATE_W     = 3;

  typedef enum logic [STATE_W-1:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } ctrl_state_t;

  typedef logic [2*WIDTH_M_DEF-1:0] product_t;

endpackage

// File: rtl/mult_acc_shift.sv
// {carry,hi,lo} register with a fused accumulate-then-shift step and an operand load.
module mult_acc_shift
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH_M = WIDTH_M_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [WIDTH_M-1:0] load_lo,
  input  logic               add_en,
  input  logic               shift_en,
  input  logic [WIDTH_M-1:0] addend,
  output logic [WIDTH_M-1:0] hi,
  output logic [WIDTH_M-1:0] lo,
  output logic [WIDTH_M-1:0] hi_nxt_c,
  output logic [WIDTH_M-1:0] lo_nxt_c
);

  logic               carry;
  logic               carry_nxt;
  logic               c_add;
  logic [WIDTH_M-1:0] hi_add;
  logic [WIDTH_M:0]   sum;

  assign sum = {1'b0, hi} + {1'b0, addend};

  // The shift sees the post-add value so add+shift completes in one cycle.
  always_comb begin
    c_add     = carry;
    hi_add    = hi;
    carry_nxt = carry;
    hi_nxt_c  = hi;
    lo_nxt_c  = lo;
    if (add_en) begin
      c_add  = sum[WIDTH_M];
      hi_add = sum[WIDTH_M-1:0];
    end
    carry_nxt = c_add;
    hi_nxt_c  = hi_add;
    if (shift_en) begin
      carry_nxt = 1'b0;
      hi_nxt_c  = {c_add, hi_add[WIDTH_M-1:1]};
      lo_nxt_c  = {hi_add[0], lo[WIDTH_M-1:1]};
    end
    if (load) begin
      carry_nxt = 1'b0;
      hi_nxt_c  = '0;
      lo_nxt_c  = load_lo;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      carry <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      carry <= carry_nxt;
      hi    <= hi_nxt_c;
      lo    <= lo_nxt_c;
    end
  end

endmodule

// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath: operand load, shift counting and valid/ready product port.
module mult_datapath
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH_M = WIDTH_M_DEF,
  parameter int unsigned WIDTH_C = WIDTH_C_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH_M-1:0]   multiplicand,
  input  logic [WIDTH_M-1:0]   multiplier,
  input  logic                 add_signal,
  input  logic                 shift_signal,
  input  logic                 mux_signal,
  output logic                 multiplier_lsb,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH_M-1:0] product,
  output logic                 product_valid,
  input  logic                 product_ready
);

  logic [WIDTH_M-1:0] a_q;
  logic [WIDTH_C-1:0] count;
  logic [WIDTH_M-1:0] hi;
  logic [WIDTH_M-1:0] lo;
  logic [WIDTH_M-1:0] hi_nxt_c;
  logic [WIDTH_M-1:0] lo_nxt_c;
  logic [WIDTH_M-1:0] addend_c;
  logic               accept_c;
  logic               add_en_c;
  logic               shift_en_c;
  logic               last_shift_c;

  assign accept_c     = start & ~busy & (~product_valid | product_ready);
  assign add_en_c     = busy & add_signal;
  assign shift_en_c   = busy & shift_signal;
  assign addend_c     = mux_signal ? a_q : '0;
  assign last_shift_c = shift_en_c & (count == WIDTH_C'(WIDTH_M - 1));

  mult_acc_shift #(
    .WIDTH_M (WIDTH_M)
  ) u_acc (
    .clk      (clk),
    .reset    (reset),
    .load     (accept_c),
    .load_lo  (multiplier),
    .add_en   (add_en_c),
    .shift_en (shift_en_c),
    .addend   (addend_c),
    .hi       (hi),
    .lo       (lo),
    .hi_nxt_c (hi_nxt_c),
    .lo_nxt_c (lo_nxt_c)
  );

  assign multiplier_lsb = lo[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q           <= '0;
      count         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      product       <= '0;
      product_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept_c) begin
        a_q   <= multiplicand;
        count <= '0;
        busy  <= 1'b1;
      end else if (shift_en_c) begin
        count <= count + WIDTH_C'(1);
        if (last_shift_c) begin
          busy    <= 1'b0;
          done    <= 1'b1;
          product <= {hi_nxt_c, lo_nxt_c};
        end
      end
      // A start accepted alongside ready keeps the old result visible until replaced.
      if (last_shift_c) begin
        product_valid <= 1'b1;
      end else if (product_valid && product_ready && !accept_c) begin
        product_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mult_datapath.sv
// Scenario bench for mult_datapath with a bit-level model and a product scoreboard.
module tb_mult_datapath;
  import mult_pkg::*;

  localparam int unsigned W = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           add_signal;
  logic           shift_signal;
  logic           mux_signal;
  logic           multiplier_lsb;
  logic           busy;
  logic           done;
  product_t       product;
  logic           product_valid;
  logic           product_ready;

  int errors = 0;
  int checks = 0;
  product_t exp_q[$];

  logic [W-1:0] m_a, m_hi, m_lo;
  logic         m_c, m_busy;
  int           m_cnt;

  always #5 clk = ~clk;

  mult_datapath dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .multiplicand   (multiplicand),
    .multiplier     (multiplier),
    .add_signal     (add_signal),
    .shift_signal   (shift_signal),
    .mux_signal     (mux_signal),
    .multiplier_lsb (multiplier_lsb),
    .busy           (busy),
    .done           (done),
    .product        (product),
    .product_valid  (product_valid),
    .product_ready  (product_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_a = '0; m_hi = '0; m_lo = '0; m_c = 1'b0; m_busy = 1'b0; m_cnt = 0;
  endtask

  task automatic model_load(input logic [W-1:0] a, input logic [W-1:0] b);
    m_a = a; m_lo = b; m_hi = '0; m_c = 1'b0; m_cnt = 0; m_busy = 1'b1;
    exp_q.push_back(product_t'(a) * product_t'(b));
  endtask

  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b, input bit accept);
    start = 1'b1; multiplicand = a; multiplier = b;
    tick();
    start = 1'b0;
    if (accept) model_load(a, b);
    checks++;
    if (busy !== m_busy) begin
      errors++; $display("FAIL start_busy: got %b want %b", busy, m_busy);
    end
    checks++;
    if (multiplier_lsb !== m_lo[0]) begin
      errors++; $display("FAIL start_lsb: got %b want %b", multiplier_lsb, m_lo[0]);
    end
  endtask

  // One controller cycle: model update, then per-cycle outputs and scoreboard on completion.
  task automatic cycle(input logic add, input logic shift, input logic mux);
    logic         c;
    logic [W-1:0] h;
    logic [W:0]   s;
    bit           fin;
    product_t     e;
    fin = 0;
    add_signal = add; shift_signal = shift; mux_signal = mux;
    c = m_c; h = m_hi;
    if (m_busy && add) begin
      s = {1'b0, m_hi} + {1'b0, (mux ? m_a : {W{1'b0}})};
      c = s[W]; h = s[W-1:0];
    end
    if (m_busy && shift) begin
      m_lo = {h[0], m_lo[W-1:1]};
      m_hi = {c, h[W-1:1]};
      m_c  = 1'b0;
      m_cnt++;
      if (m_cnt == W) begin m_busy = 1'b0; fin = 1; end
    end else begin
      m_c = c; m_hi = h;
    end
    tick();
    add_signal = 1'b0; shift_signal = 1'b0; mux_signal = 1'b0;
    checks++;
    if (done !== fin) begin
      errors++; $display("FAIL done: got %b want %b (shift %0d)", done, fin, m_cnt);
    end
    checks++;
    if (busy !== m_busy) begin
      errors++; $display("FAIL busy: got %b want %b", busy, m_busy);
    end
    checks++;
    if (multiplier_lsb !== m_lo[0]) begin
      errors++; $display("FAIL lsb: got %b want %b", multiplier_lsb, m_lo[0]);
    end
    checks++;
    if (dut.u_acc.carry !== m_c) begin
      errors++; $display("FAIL carry: got %b want %b", dut.u_acc.carry, m_c);
    end
    if (fin) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL scoreboard: completion with no expected product");
      end else begin
        e = exp_q.pop_front();
        if (product !== e) begin
          errors++; $display("FAIL product: got %h want %h", product, e);
        end
      end
      checks++;
      if (product_valid !== 1'b1) begin
        errors++; $display("FAIL product_valid_set: got %b want 1", product_valid);
      end
    end
  endtask

  task automatic run_ctrl(input int bits);
    for (int i = 0; i < bits; i++) begin
      cycle(1'b1, 1'b0, m_lo[0]);
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic consume();
    product_ready = 1'b1;
    tick();
    product_ready = 1'b0;
    checks++;
    if (product_valid !== 1'b0) begin
      errors++; $display("FAIL consume: product_valid got %b want 0", product_valid);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({busy, done, product_valid, multiplier_lsb} !== 4'b0 || product !== '0) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b valid=%b lsb=%b product=%h want all 0",
               tag, busy, done, product_valid, multiplier_lsb, product);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; multiplicand = '0; multiplier = '0;
    add_signal = 1'b0; shift_signal = 1'b0; mux_signal = 1'b0; product_ready = 1'b0;
    model_reset();
    tick(); tick();
    check_all_zero("reset_state");
    checks++;
    if (dut.count !== 5'd0) begin
      errors++; $display("FAIL reset_count: got %0d want 0", dut.count);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    do_start(16'd3, 16'd5, 1);
    run_ctrl(16);
    checks++;
    if (product !== 32'h0000000F) begin
      errors++; $display("FAIL basic_3x5: got %h want 0000000f", product);
    end
    consume();
  endtask

  task automatic test_max();
    do_start(16'hFFFF, 16'hFFFF, 1);
    run_ctrl(16);
    checks++;
    if (product !== 32'hFFFE0001) begin
      errors++; $display("FAIL max_ffff: got %h want fffe0001", product);
    end
    consume();
  endtask

  task automatic test_fused();
    do_start(16'h8000, 16'h0001, 1);
    cycle(1'b1, 1'b1, m_lo[0]);
    checks++;
    if (dut.count !== 5'd1) begin
      errors++; $display("FAIL fused_count: got %0d want 1", dut.count);
    end
    checks++;
    if ({dut.u_acc.carry, dut.u_acc.hi, dut.u_acc.lo} !== 33'h0_4000_0000) begin
      errors++; $display("FAIL fused_state: got %h want 040000000",
                         {dut.u_acc.carry, dut.u_acc.hi, dut.u_acc.lo});
    end
    for (int i = 1; i < 16; i++) cycle(1'b1, 1'b1, m_lo[0]);
    checks++;
    if (product !== 32'h00008000) begin
      errors++; $display("FAIL fused_product: got %h want 00008000", product);
    end
    consume();
  endtask

  task automatic test_start_ignored();
    do_start(16'd7, 16'd9, 1);
    run_ctrl(4);
    start = 1'b1; multiplicand = 16'd3; multiplier = 16'd3;
    run_ctrl(1);
    start = 1'b0;
    run_ctrl(11);
    checks++;
    if (product !== 32'd63) begin
      errors++; $display("FAIL start_ignored: got %0d want 63", product);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    do_start(16'h1234, 16'h5678, 1);
    run_ctrl(8);
    #2 reset = 1'b0;
    #1;
    check_all_zero("reset_mid");
    exp_q.delete();
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b0);
    do_start(16'd2, 16'd2, 1);
    run_ctrl(16);
    checks++;
    if (product !== 32'd4) begin
      errors++; $display("FAIL reset_then_2x2: got %0d want 4", product);
    end
    consume();
  endtask

  task automatic test_handshake();
    do_start(16'd11, 16'd13, 1);
    run_ctrl(16);
    start = 1'b1; multiplicand = 16'd5; multiplier = 16'd6;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if (product_valid !== 1'b1 || product !== 32'd143) begin
      errors++; $display("FAIL hold: valid=%b product=%0d want 1/143", product_valid, product);
    end
    product_ready = 1'b1;
    tick();
    start = 1'b0; product_ready = 1'b0;
    model_load(16'd5, 16'd6);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL ready_start_busy: got %b want 1", busy);
    end
    checks++;
    if (product_valid !== 1'b1 || product !== 32'd143) begin
      errors++; $display("FAIL ready_start_keep: valid=%b product=%0d want 1/143",
                         product_valid, product);
    end
    run_ctrl(16);
    consume();
  endtask

  task automatic test_idle_ctrl();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1);
    checks++;
    if (dut.count !== 5'd16 || product !== 32'd30) begin
      errors++; $display("FAIL idle_ctrl: count=%0d product=%0d want 16/30", dut.count, product);
    end
    product_ready = 1'b1;
    tick();
    product_ready = 1'b0;
    checks++;
    if (product_valid !== 1'b0) begin
      errors++; $display("FAIL idle_ready: valid got %b want 0", product_valid);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int n = 0; n < 4; n++) begin
      a = W'($urandom);
      b = W'($urandom);
      do_start(a, b, 1);
      if (n[0]) run_ctrl(16);
      else for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, m_lo[0]);
      consume();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_fused();
    test_start_ignored();
    test_reset_mid();
    test_handshake();
    test_idle_ctrl();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover: %0d products never produced", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
